display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed driver for a bank of common-select seven-segment digits. Holds a multi-digit hex value, scans one digit at a time at a prescaled rate, and presents the current digit's 4-bit code on `bcd` for the downstream `sevensegmentdecoder` while asserting the matching one-hot digit enable. New values are double-buffered and applied only at frame boundaries, so a digit never changes part-way through a scan. Optional leading-zero blanking is supported.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; value width is 4*DIGITS.
- `PRESCALE`, 1000: clock cycles each digit stays enabled; minimum 2.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `load`  input  1  one-cycle strobe; captures `value` into the shadow register.
- `value`  input  4*DIGITS  hex digits; nibble 0 (bits 3:0) is the rightmost/least-significant digit.
- `lz_en`  input  1  leading-zero blanking enable; sampled every cycle.
- `bcd`  output  4  code of the currently scanned digit, feeds `sevensegmentdecoder.bcd`.
- `digit_en`  output  DIGITS  one-hot active-high enable of the scanned digit; all-zero when the slot is blanked.
- `frame_done`  output  1  one-cycle pulse in the cycle after the last digit's slot ends.
- `pending`  output  1  shadow holds a value not yet applied to the display.

## Operation
- State: prescale counter `pcnt` (0..PRESCALE-1), digit index `idx` (0..DIGITS-1), `shadow` register, `disp` register, `pending` flag.
- `pcnt` increments every cycle. At PRESCALE-1 it wraps to 0 and `idx` advances. `idx` wraps from DIGITS-1 to 0.
- Frame boundary is the cycle in which `pcnt`=PRESCALE-1 and `idx`=DIGITS-1. At that edge:
  - `idx` goes to 0.
  - if `pending`=1, `disp` takes `shadow` and `pending` clears.
  - `frame_done` is 1 for the following cycle.
- `load`=1 sets `shadow` to `value` and `pending` to 1. Repeated loads within a frame overwrite `shadow`; only the last one is displayed.
- Load coinciding with a frame boundary:
  - `disp` takes the pre-load `shadow` contents if `pending` was set, otherwise `disp` is unchanged.
  - `shadow` takes the new `value` and `pending` stays or becomes 1.
  - The new value appears at the next boundary.
- Outputs:
  - `bcd` = `disp[4*idx+3 : 4*idx]`.
  - `digit_en` = (1 << `idx`) unless the slot is blanked.
- Blanking: with `lz_en`=1, digit k (k ≥ 1) is blanked when `disp` nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked, so 0 displays as "0". `bcd` still carries the nibble when a slot is blanked.
- All outputs derive from registered state only. There is no combinational path from `load`/`value` to outputs. `lz_en` is the sole exception and affects `digit_en` in the same cycle.

## Timing
- Reset values: `pcnt`=0, `idx`=0, `shadow`=0, `disp`=0, `pending`=0, `bcd`=0, `digit_en`=...0001, `frame_done`=0.
- Reset mid-scan or mid-pending discards the shadow and returns to the reset state on the next edge.
- Each digit is enabled for exactly PRESCALE cycles. A frame is DIGITS*PRESCALE cycles.
- Load-to-display latency: from 1 cycle (load in the cycle before a boundary) up to DIGITS*PRESCALE cycles. `pending` rises on the edge after `load`.
- `frame_done` period is exactly DIGITS*PRESCALE cycles. The first pulse comes DIGITS*PRESCALE cycles after reset deassertion.
- `digit_en` is never multi-hot in any cycle.

## Test plan
Use DIGITS=4, PRESCALE=4.
- Reset, then idle 16 cycles:
  - `digit_en` steps 0001, 0010, 0100, 1000, four cycles each.
  - `bcd`=0 throughout.
  - `frame_done` pulses at cycle 16.
- Load `value`=16'h1A2F at cycle 2:
  - `pending`=1 from cycle 3; display unchanged until the boundary.
  - Next frame shows `bcd`=F, 2, A, 1 on digits 0..3.
  - `pending`=0 after the boundary.
- Load 16'h1111 then 16'h2222 in the same frame: the next frame shows only 2,2,2,2.
- Load 16'h00A7 exactly on a boundary cycle:
  - The following frame still shows the old `disp`, and `pending` stays 1.
  - 7, A, 0, 0 appear one frame later.
- `lz_en`=1 with `disp`=16'h0030: `digit_en` = 0001, 0010, 0000, 0000. With `disp`=0: `digit_en` = 0001, 0000, 0000, 0000.
- Load 16'hBEEF, assert `reset` one cycle before the boundary:
  - All state returns to reset values and `pending`=0.
  - The next frame shows 0,0,0,0.

Source files
------------

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner: one digit enabled per PRESCALE-cycle slot,
// with a double-buffered display value swapped only at frame boundaries.

module display_scanner_digit #(
  parameter int DIGITS = 4,
  parameter int K      = 0,
  parameter int IW     = 2
) (
  input  logic [DIGITS-1:0][3:0] disp,
  input  logic [IW-1:0]          idx,
  input  logic                   lz_en,
  output logic                   en
);
  logic [4*DIGITS-1:0] flat;
  logic [4*DIGITS-1:0] upper;
  logic                blank;

  assign flat  = disp;
  assign upper = flat >> (4*K);
  // Digit 0 is never blanked so that an all-zero value still shows "0".
  assign blank = lz_en && (K != 0) && (upper == '0);
  assign en    = (idx == IW'(K)) && !blank;
endmodule

module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_en,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done,
  output logic                  pending
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]          pcnt;
  logic [IW-1:0]          idx;
  logic [DIGITS-1:0][3:0] shadow;
  logic [DIGITS-1:0][3:0] disp;
  logic                   slot_end;
  logic                   frame_end;

  assign slot_end  = (pcnt == PW'(PRESCALE-1));
  assign frame_end = slot_end && (idx == IW'(DIGITS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= slot_end ? '0 : pcnt + 1'b1;
      frame_done <= frame_end;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      // A load on the boundary still hands the older shadow to disp; the new
      // value waits for the next boundary.
      if (frame_end && pending)
        disp <= shadow;
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  assign bcd = disp[idx];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    display_scanner_digit #(.DIGITS(DIGITS), .K(k), .IW(IW)) u_digit (
      .disp  (disp),
      .idx   (idx),
      .lz_en (lz_en),
      .en    (digit_en[k])
    );
  end
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIGITS=4, PRESCALE=4 (16-cycle frames).

module tb_display_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        pending;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  display_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .bcd        (bcd),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int target);
    while (t < target) tick();
  endtask

  // Checks one frame starting at 'base': bcd per slot and which slots are enabled.
  task automatic show(input int base, input logic [15:0] v, input logic [3:0] vis);
    for (int s = 0; s < 4; s++) begin
      goto(base + 4*s + 1);
      chk($sformatf("bcd_s%0d", s), 32'(bcd), 32'(v[4*s +: 4]));
      chk($sformatf("en_s%0d", s), 32'(digit_en), vis[s] ? 32'(1 << s) : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    t = 0;

    // reset state and idle frame
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    for (int c = 0; c < 16; c++) begin
      chk("idle_en", 32'(digit_en), 32'(1 << (c/4)));
      chk("idle_bcd", 32'(bcd), 32'd0);
      chk("idle_fd", 32'(frame_done), 32'd0);
      tick();
    end
    chk("fd_first", 32'(frame_done), 32'd1);
    chk("fd_en_wrap", 32'(digit_en), 32'd1);
    tick();
    chk("fd_single", 32'(frame_done), 32'd0);

    // load mid-frame
    goto(18);
    load = 1'b1; value = 16'h1A2F;
    tick();
    load = 1'b0;
    chk("ld_pending", 32'(pending), 32'd1);
    chk("ld_bcd_hold", 32'(bcd), 32'd0);
    goto(31);
    chk("ld_pending_pre", 32'(pending), 32'd1);
    chk("ld_bcd_pre", 32'(bcd), 32'd0);
    chk("ld_en_pre", 32'(digit_en), 32'd8);
    tick();
    chk("ld_pending_clr", 32'(pending), 32'd0);
    chk("ld_fd", 32'(frame_done), 32'd1);
    show(32, 16'h1A2F, 4'hF);

    // two loads in one frame: last wins
    goto(50);
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    goto(52);
    load = 1'b1; value = 16'h2222;
    tick();
    load = 1'b0;
    goto(64);
    chk("dbl_pending", 32'(pending), 32'd0);
    show(64, 16'h2222, 4'hF);

    // load on the boundary cycle
    goto(79);
    load = 1'b1; value = 16'h00A7;
    tick();
    load = 1'b0;
    chk("bnd_pending", 32'(pending), 32'd1);
    show(80, 16'h2222, 4'hF);
    goto(96);
    chk("bnd_pending_clr", 32'(pending), 32'd0);
    show(96, 16'h00A7, 4'hF);

    // leading-zero blanking
    load = 1'b1; value = 16'h0030;
    tick();
    load = 1'b0;
    lz_en = 1'b1;
    show(112, 16'h0030, 4'b0011);
    load = 1'b1; value = 16'h0000;
    tick();
    load = 1'b0;
    show(128, 16'h0000, 4'b0001);
    lz_en = 1'b0;
    #1;
    chk("lz_same_cycle", 32'(digit_en), 32'd8);

    // reset while a load is pending
    goto(146);
    load = 1'b1; value = 16'hBEEF;
    tick();
    load = 1'b0;
    chk("rs_pending_set", 32'(pending), 32'd1);
    goto(158);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    t = 0;
    chk("rs_pending", 32'(pending), 32'd0);
    chk("rs_en", 32'(digit_en), 32'd1);
    chk("rs_bcd", 32'(bcd), 32'd0);
    chk("rs_fd", 32'(frame_done), 32'd0);
    goto(16);
    chk("rs_fd_first", 32'(frame_done), 32'd1);
    chk("rs_pending_after", 32'(pending), 32'd0);
    show(16, 16'h0000, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
